// File: rtl/bulk_line_sequencer_if.sv
// Line-wide request/response port between the cache-side mux and the line sequencer.
// One request carries a whole line; one response returns a whole line.
interface bulk_read_interface #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 64,
  parameter int LINE_SIZE = 8
);
  logic                          req_valid;
  logic                          req_ready;
  logic [ADDR_W-1:0]             req_addr;
  logic                          req_write;
  logic [LINE_SIZE*DATA_W-1:0]   req_wdata;
  logic [LINE_SIZE*DATA_W/8-1:0] req_wstrb;
  logic                          resp_valid;
  logic [LINE_SIZE*DATA_W-1:0]   resp_rdata;
  logic                          dumping_cache;

  modport slave (
    input  req_valid, req_addr, req_write, req_wdata, req_wstrb,
    output req_ready, resp_valid, resp_rdata
  );

  modport master (
    output req_valid, req_addr, req_write, req_wdata, req_wstrb, dumping_cache,
    input  req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/bulk_line_sequencer.sv
// Splits one line request into LINE_SIZE pipelined word accesses and returns the assembled line.
// Line response LINE_SIZE+2 cycles after accept with no stalls; word fields hold while mem_req_ready is low.
module bulk_line_sequencer #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 64,
  parameter int LINE_SIZE = 8
) (
  input  logic                clk,
  input  logic                rst,
  bulk_read_interface.slave   line,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_write,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wstrb,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_rdata,
  output logic                busy
);
  localparam int SB  = DATA_W / 8;
  localparam int CW  = $clog2(LINE_SIZE) + 1;
  localparam int IW  = $clog2(LINE_SIZE);
  localparam int BSH = $clog2(SB);
  localparam int LSH = $clog2(LINE_SIZE * SB);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic              wr;
  logic [DATA_W-1:0] line_buf [LINE_SIZE];
  logic [SB-1:0]     strb_buf [LINE_SIZE];
  logic [CW-1:0]     issue_cnt;
  logic [CW-1:0]     resp_cnt;
  logic [CW-1:0]     issue_nxt;
  logic              issue_fire;
  logic              resp_take;

  assign issue_fire = (state == RUN) && mem_req_valid && mem_req_ready;
  // Responses beyond the number of issued words are strays and are dropped.
  assign resp_take  = (state == RUN) && mem_resp_valid && (resp_cnt != issue_cnt);
  assign issue_nxt  = issue_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      base          <= '0;
      wr            <= 1'b0;
      issue_cnt     <= '0;
      resp_cnt      <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_write <= 1'b0;
      mem_req_wdata <= '0;
      mem_req_wstrb <= '0;
      for (int i = 0; i < LINE_SIZE; i++) begin
        line_buf[i] <= '0;
        strb_buf[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (line.req_valid) begin
            base          <= {line.req_addr[ADDR_W-1:LSH], {LSH{1'b0}}};
            wr            <= line.req_write;
            issue_cnt     <= '0;
            resp_cnt      <= '0;
            for (int i = 0; i < LINE_SIZE; i++) begin
              line_buf[i] <= line.req_wdata[i*DATA_W +: DATA_W];
              strb_buf[i] <= line.req_wstrb[i*SB +: SB];
            end
            // Word 0 is presented straight from the request so it is valid on the next cycle.
            mem_req_valid <= 1'b1;
            mem_req_addr  <= {line.req_addr[ADDR_W-1:LSH], {LSH{1'b0}}};
            mem_req_write <= line.req_write;
            mem_req_wdata <= line.req_wdata[DATA_W-1:0];
            mem_req_wstrb <= line.req_wstrb[SB-1:0];
            state         <= RUN;
          end
        end
        RUN: begin
          if (issue_fire) begin
            issue_cnt <= issue_nxt;
            if (issue_nxt == CW'(LINE_SIZE)) begin
              mem_req_valid <= 1'b0;
            end else begin
              mem_req_addr  <= base + (ADDR_W'(issue_nxt) << BSH);
              mem_req_wdata <= line_buf[issue_nxt[IW-1:0]];
              mem_req_wstrb <= strb_buf[issue_nxt[IW-1:0]];
            end
          end
          if (resp_take) begin
            if (!wr) line_buf[resp_cnt[IW-1:0]] <= mem_resp_rdata;
            resp_cnt <= resp_cnt + 1'b1;
            if (resp_cnt == CW'(LINE_SIZE - 1)) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign line.req_ready  = (state == IDLE);
  assign line.resp_valid = (state == DONE);
  assign busy            = (state != IDLE);

  always_comb begin
    for (int i = 0; i < LINE_SIZE; i++) begin
      line.resp_rdata[i*DATA_W +: DATA_W] = line_buf[i];
    end
  end
endmodule

// File: doc/bulk_line_sequencer.md
# bulk_line_sequencer

Converts one full-line request on a `bulk_read_interface` into `LINE_SIZE` single-word accesses on a word-wide memory port, then returns the assembled line as a single response. It sits below the cache-side multiplexer, between the shared line-request port and a backing memory that transfers one `DATA_W` word per transaction. It pipelines word issue: up to `LINE_SIZE` word accesses may be outstanding, and the memory returns responses in order.

## Interface
- `DATA_W`, default 64: word width in bits; a multiple of 8.
- `ADDR_W`, default 64: byte-address width.
- `LINE_SIZE`, default 8: words per line; a power of two, at least 2.
- `clk` input 1: the only clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `line` `bulk_read_interface.slave`: fields used are `req_valid`, `req_ready`, `req_addr`, `req_write`, `req_wdata`, `req_wstrb`, `resp_valid` and `resp_rdata`.
  - `req_wdata` and `resp_rdata` are `LINE_SIZE` × `DATA_W` bits.
  - `req_wstrb` is `LINE_SIZE` × `DATA_W/8` bits.
  - `dumping_cache` is ignored.
- `mem_req_valid` output 1: word request valid.
- `mem_req_ready` input 1: memory accepts the word request.
- `mem_req_addr` output `ADDR_W`: word byte address.
- `mem_req_write` output 1: 1 = write.
- `mem_req_wdata` output `DATA_W`: write data.
- `mem_req_wstrb` output `DATA_W/8`: byte strobes.
- `mem_resp_valid` input 1: one in-order response, for each accepted word, reads and writes alike.
- `mem_resp_rdata` input `DATA_W`: read data; ignored for writes.
- `busy` output 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE**
  - `line.req_ready` = 1.
  - When `req_valid` is high, the request is accepted:
    - capture `base = req_addr` with the low `log2(LINE_SIZE*DATA_W/8)` bits cleared;
    - capture `req_write` and `req_wstrb`;
    - load `req_wdata` into the line buffer;
    - clear `issue_cnt` and `resp_cnt`;
    - go to RUN.
- **RUN**
  - `mem_req_valid` = (`issue_cnt` < `LINE_SIZE`).
  - `mem_req_addr` = `base + issue_cnt*(DATA_W/8)`.
  - `mem_req_wdata` and `mem_req_wstrb` = word or strobe slice [`issue_cnt`] of the captured line.
  - `mem_req_write` = the captured write bit.
  - `issue_cnt` increments on `mem_req_valid && mem_req_ready`.
  - On each `mem_resp_valid`, `resp_cnt` increments. For reads, `mem_resp_rdata` is also written into buffer word [`resp_cnt`].
  - When the response that brings `resp_cnt` to `LINE_SIZE` arrives, go to DONE.
- **DONE**
  - `line.resp_valid` = 1 for exactly one cycle, then go to IDLE.
- `line.resp_rdata` = the line buffer at all times.
  - For reads, it holds the read line until the next accept.
  - For writes, it holds the captured write data (strobes not applied).
- `line.req_ready` = 0 in RUN and DONE.
- Counters are `$clog2(LINE_SIZE)+1` bits wide. They saturate at `LINE_SIZE` and never wrap.
- Write beats whose strobe is all-zero are still issued.
- A `mem_resp_valid` in IDLE or DONE, or with `resp_cnt` already equal to `issue_cnt`, is ignored: no state change.
- A response may arrive in the same cycle that a word request is accepted; both counters update in that cycle.

## Timing
- Reset values:
  - state IDLE, so `line.req_ready` = 1 on the first cycle after reset;
  - `line.resp_valid` = 0;
  - `mem_req_valid` = 0;
  - `busy` = 0;
  - `mem_req_addr`, `mem_req_wdata`, `mem_req_wstrb`, `mem_req_write` = 0;
  - line buffer = 0; counters = 0.
- Reset while in RUN or DONE:
  - the transaction is aborted with no response; the next cycle is IDLE;
  - the memory is reset by the same `rst`.
- Let a line request be accepted in cycle T.
  - Word 0 appears on `mem_req_valid` at T+1.
  - With `mem_req_ready` held at 1 and memory responding one cycle after accept, word *i* is issued at T+1+*i* and its response arrives at T+2+*i*.
  - `line.resp_valid` is high at T+`LINE_SIZE`+2.
- While `mem_req_valid && !mem_req_ready`, `mem_req_addr`, `wdata`, `wstrb` and `write` are held stable.
- Back-to-back line requests: the next accept is no earlier than the cycle after the DONE cycle. Minimum period is `LINE_SIZE`+3 cycles.

## Test plan
- **Read, no stall.** Read at `req_addr` 0x1000, memory returns word *i* = 0xA0+*i*, `mem_req_ready` = 1.
  - `mem_req_addr` runs 0x1000, 0x1008 … 0x1038.
  - `resp_valid` at T+10.
  - `resp_rdata` words = 0xA0…0xA7.
- **Unaligned address.** Read at `req_addr` 0x1234.
  - The first word address is 0x1200.
- **Backpressure.** `mem_req_ready` alternates 0/1, with response latency 3.
  - Every word is issued exactly once.
  - Request fields are stable while stalled.
  - `resp_valid` follows the 8th response by 1 cycle.
  - `resp_rdata` is correct.
- **Write line.** Write with word *i* = 0x11*i*, `req_wstrb` = 0xFF for even words and 0x00 for odd words.
  - Eight writes are issued with the matching data and strobes.
  - `resp_valid` follows the 8th ack.
  - `resp_rdata` = the written line.
- **Reset mid-burst.** Assert `rst` for 1 cycle after the 3rd word is accepted.
  - No `resp_valid`; `mem_req_valid` = 0.
  - `req_ready` = 1 on the next cycle.
  - A following read completes correctly.
- **Back-to-back and stray responses.** Hold `req_valid` high for two reads, and inject a stray `mem_resp_valid` in IDLE.
  - The second accept happens the cycle after the first `resp_valid`.
  - The stray pulse is ignored; counters are unchanged.
